// File: rtl/icache_mshr_downstream_arb_if.sv
// Request/response bundle between the MSHR entry array, the downstream
// arbiter and the L2/bus port. The arbiter uses the slave modport and the
// MSHR/downstream side uses the master modport. The payload is opaque to the
// arbiter, so it is carried as a plain vector of PLD_W bits.
interface icache_mshr_downstream_arb_if #(
  parameter  int MSHR_ENTRY_NUM = 8,
  parameter  int OST_MAX        = 4,
  parameter  int PLD_W          = 32,
  localparam int ID_W           = (MSHR_ENTRY_NUM > 1) ? $clog2(MSHR_ENTRY_NUM) : 1,
  localparam int CNT_W          = $clog2(OST_MAX + 1)
);

  typedef logic [PLD_W-1:0] pc_req_t;

  // Per-entry request side
  logic    [MSHR_ENTRY_NUM-1:0] entry_txreq_vld;
  pc_req_t [MSHR_ENTRY_NUM-1:0] entry_txreq_pld;
  logic    [MSHR_ENTRY_NUM-1:0] entry_txreq_rdy;

  // Downstream request side
  logic                         downstream_txreq_vld;
  logic                         downstream_txreq_rdy;
  pc_req_t                      downstream_txreq_pld;
  logic    [ID_W-1:0]           downstream_txreq_id;

  // Downstream response and status
  logic                         downstream_rsp_vld;
  logic    [ID_W-1:0]           downstream_rsp_id;
  logic    [MSHR_ENTRY_NUM-1:0] linefill_done;
  logic    [CNT_W-1:0]          ost_cnt;
  logic                         ost_err;

  modport slave (
    input  entry_txreq_vld, entry_txreq_pld, downstream_txreq_rdy,
           downstream_rsp_vld, downstream_rsp_id,
    output entry_txreq_rdy, downstream_txreq_vld, downstream_txreq_pld,
           downstream_txreq_id, linefill_done, ost_cnt, ost_err
  );

  modport master (
    output entry_txreq_vld, entry_txreq_pld, downstream_txreq_rdy,
           downstream_rsp_vld, downstream_rsp_id,
    input  entry_txreq_rdy, downstream_txreq_vld, downstream_txreq_pld,
           downstream_txreq_id, linefill_done, ost_cnt, ost_err
  );

endinterface

// File: rtl/icache_mshr_downstream_arb.sv
// Shares the single icache downstream request channel between all MSHR
// entries: round-robin pick among requesting entries, one registered output
// stage, a credit counter bounding outstanding linefills (a credit is taken
// when a request enters the output stage), and decode of linefill responses
// into one-cycle per-entry done pulses.
module icache_mshr_downstream_arb #(
  parameter  int MSHR_ENTRY_NUM = 8,
  parameter  int OST_MAX        = 4,
  parameter  int PLD_W          = 32,
  localparam int ID_W           = (MSHR_ENTRY_NUM > 1) ? $clog2(MSHR_ENTRY_NUM) : 1,
  localparam int CNT_W          = $clog2(OST_MAX + 1)
) (
  input logic                          clk,
  input logic                          rst_n,
  icache_mshr_downstream_arb_if.slave  bus
);

  // Round-robin pointer: last granted entry
  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  // Output stage
  logic                      out_vld_q, out_vld_d;
  logic [PLD_W-1:0]          out_pld_q, out_pld_d;
  logic [ID_W-1:0]           out_id_q, out_id_d;
  // Credits and error flag
  logic [CNT_W-1:0]          ost_cnt_q, ost_cnt_d;
  logic                      ost_err_q, ost_err_d;
  // Response decode
  logic [MSHR_ENTRY_NUM-1:0] linefill_done_q, linefill_done_d;

  logic                      win_found;
  logic [ID_W-1:0]           win_id;
  logic [ID_W-1:0]           cand;
  logic                      credit_ok;
  logic                      out_free;
  logic                      load;

  // Round-robin search starting just above the last winner, wrapping around
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 1; i <= MSHR_ENTRY_NUM; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % MSHR_ENTRY_NUM);
      if (!win_found && bus.entry_txreq_vld[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign credit_ok = (ost_cnt_q < CNT_W'(OST_MAX));
  assign out_free  = ~out_vld_q | bus.downstream_txreq_rdy;
  assign load      = win_found & credit_ok & out_free;

  // Accept goes only to the winning entry, and only when it is actually loaded
  always_comb begin
    bus.entry_txreq_rdy = '0;
    if (load) begin
      bus.entry_txreq_rdy[win_id] = 1'b1;
    end
  end

  // Output stage: load the winner, otherwise drop valid once it transfers
  always_comb begin
    out_vld_d = out_vld_q;
    out_pld_d = out_pld_q;
    out_id_d  = out_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_pld_d = bus.entry_txreq_pld[win_id];
      out_id_d  = win_id;
      rr_ptr_d  = win_id;
    end else if (bus.downstream_txreq_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  // Credit counter: +1 on load, -1 on response; a response with no credit
  // outstanding is flagged and does not underflow
  always_comb begin
    ost_cnt_d = ost_cnt_q;
    ost_err_d = ost_err_q;
    if (bus.downstream_rsp_vld && (ost_cnt_q == '0)) begin
      ost_err_d = 1'b1;
      ost_cnt_d = ost_cnt_q + CNT_W'(load);
    end else if (load && !bus.downstream_rsp_vld) begin
      ost_cnt_d = ost_cnt_q + CNT_W'(1);
    end else if (!load && bus.downstream_rsp_vld) begin
      ost_cnt_d = ost_cnt_q - CNT_W'(1);
    end
  end

  // Response id decode; ids outside the entry range produce no pulse
  always_comb begin
    linefill_done_d = '0;
    for (int i = 0; i < MSHR_ENTRY_NUM; i++) begin
      linefill_done_d[i] = bus.downstream_rsp_vld && (bus.downstream_rsp_id == ID_W'(i));
    end
  end

  // State registers; entry 0 has first priority after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q        <= ID_W'(MSHR_ENTRY_NUM - 1);
      out_vld_q       <= 1'b0;
      // NOTE: the payload register is reset too because it drives an output that must read 0 in reset.
      out_pld_q       <= '0;
      out_id_q        <= '0;
      ost_cnt_q       <= '0;
      ost_err_q       <= 1'b0;
      linefill_done_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rr_ptr_q        <= rr_ptr_d;
      out_vld_q       <= out_vld_d;
      out_pld_q       <= out_pld_d;
      out_id_q        <= out_id_d;
      ost_cnt_q       <= ost_cnt_d;
      ost_err_q       <= ost_err_d;
      linefill_done_q <= linefill_done_d;
    end
  end

  assign bus.downstream_txreq_vld = out_vld_q;
  assign bus.downstream_txreq_pld = out_pld_q;
  assign bus.downstream_txreq_id  = out_id_q;
  assign bus.ost_cnt              = ost_cnt_q;
  assign bus.ost_err              = ost_err_q;
  assign bus.linefill_done        = linefill_done_q;

endmodule

// File: tb/tb_icache_mshr_downstream_arb.sv
// Directed bench for icache_mshr_downstream_arb: reset state, round-robin
// order, credit limit, output stall, simultaneous load/response, underflow
// error and asynchronous reset.
module tb_icache_mshr_downstream_arb;

  localparam int N  = 8;
  localparam int OM = 4;
  localparam int PW = 16;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  icache_mshr_downstream_arb_if #(.MSHR_ENTRY_NUM(N), .OST_MAX(OM), .PLD_W(PW)) bus ();

  icache_mshr_downstream_arb #(.MSHR_ENTRY_NUM(N), .OST_MAX(OM), .PLD_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pld_of(input int i);
    return PW'(16'hC0C0 + i * 16'h0101);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    bus.entry_txreq_vld      = '0;
    bus.downstream_txreq_rdy = 1'b1;
    bus.downstream_rsp_vld   = 1'b0;
    bus.downstream_rsp_id    = '0;
    for (int i = 0; i < N; i++) bus.entry_txreq_pld[i] = pld_of(i);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ds_vld", 32'(bus.downstream_txreq_vld), 0);
    check("rst_ds_pld", 32'(bus.downstream_txreq_pld), 0);
    check("rst_ds_id",  32'(bus.downstream_txreq_id), 0);
    check("rst_cnt",    32'(bus.ost_cnt), 0);
    check("rst_err",    32'(bus.ost_err), 0);
    check("rst_done",   32'(bus.linefill_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from entry 0
    step(); bus.entry_txreq_vld = 8'h01; #1;
    check("t1_rdy", 32'(bus.entry_txreq_rdy), 32'h01);
    step(); bus.entry_txreq_vld = 8'h00; #1;
    check("t1_ds_vld", 32'(bus.downstream_txreq_vld), 1);
    check("t1_ds_id",  32'(bus.downstream_txreq_id), 0);
    check("t1_ds_pld", 32'(bus.downstream_txreq_pld), 32'(pld_of(0)));
    check("t1_cnt",    32'(bus.ost_cnt), 1);
    bus.downstream_rsp_vld = 1'b1; bus.downstream_rsp_id = 3'd0;
    step(); bus.downstream_rsp_vld = 1'b0; #1;
    check("t1_cnt_free", 32'(bus.ost_cnt), 0);
    check("t1_done",     32'(bus.linefill_done), 32'h01);
    check("t1_ds_drop",  32'(bus.downstream_txreq_vld), 0);
    step(); #1;
    check("t1_done_pulse", 32'(bus.linefill_done), 0);

    // Entries 1,3,6 requesting: order 1,3,6,1 at one request per cycle
    step(); bus.entry_txreq_vld = 8'h4A; #1;
    check("t2_rdy0", 32'(bus.entry_txreq_rdy), 32'h02);
    step(); #1;
    check("t2_id0",  32'(bus.downstream_txreq_id), 1);
    check("t2_cnt0", 32'(bus.ost_cnt), 1);
    check("t2_rdy1", 32'(bus.entry_txreq_rdy), 32'h08);
    step(); #1;
    check("t2_id1",  32'(bus.downstream_txreq_id), 3);
    check("t2_cnt1", 32'(bus.ost_cnt), 2);
    check("t2_rdy2", 32'(bus.entry_txreq_rdy), 32'h40);
    step(); #1;
    check("t2_id2",  32'(bus.downstream_txreq_id), 6);
    check("t2_cnt2", 32'(bus.ost_cnt), 3);
    check("t2_rdy3", 32'(bus.entry_txreq_rdy), 32'h02);
    step(); #1;
    check("t2_id3",     32'(bus.downstream_txreq_id), 1);
    check("t2_vld3",    32'(bus.downstream_txreq_vld), 1);
    check("t2_cnt_max", 32'(bus.ost_cnt), 4);
    check("t2_rdy_blk", 32'(bus.entry_txreq_rdy), 0);
    bus.entry_txreq_vld = 8'h00;

    // Credits exhausted with all entries requesting; one response frees one load
    step(); bus.entry_txreq_vld = 8'hFF; #1;
    check("t3_ds_idle", 32'(bus.downstream_txreq_vld), 0);
    check("t3_cnt",     32'(bus.ost_cnt), 4);
    check("t3_rdy_blk", 32'(bus.entry_txreq_rdy), 0);
    bus.downstream_rsp_vld = 1'b1; bus.downstream_rsp_id = 3'd2;
    step(); bus.downstream_rsp_vld = 1'b0; #1;
    check("t3_cnt_free", 32'(bus.ost_cnt), 3);
    check("t3_done",     32'(bus.linefill_done), 32'h04);
    check("t3_rdy_one",  32'(bus.entry_txreq_rdy), 32'h04);
    step(); bus.downstream_txreq_rdy = 1'b0;
    bus.downstream_rsp_vld = 1'b1; bus.downstream_rsp_id = 3'd1; #1;
    check("t3_ds_id",   32'(bus.downstream_txreq_id), 2);
    check("t3_cnt_re",  32'(bus.ost_cnt), 4);
    check("t3_rdy_end", 32'(bus.entry_txreq_rdy), 0);
    check("t3_done0",   32'(bus.linefill_done), 0);

    // Downstream stall: output held, no accepts even with a free credit
    for (int k = 0; k < 5; k++) begin
      step(); bus.downstream_rsp_vld = 1'b0; #1;
      check("t4_vld", 32'(bus.downstream_txreq_vld), 1);
      check("t4_id",  32'(bus.downstream_txreq_id), 2);
      check("t4_pld", 32'(bus.downstream_txreq_pld), 32'(pld_of(2)));
      check("t4_rdy", 32'(bus.entry_txreq_rdy), 0);
      check("t4_cnt", 32'(bus.ost_cnt), 3);
    end
    bus.downstream_txreq_rdy = 1'b1; #1;
    check("t4_b2b_rdy", 32'(bus.entry_txreq_rdy), 32'h08);
    step(); #1;
    check("t4_b2b_id",  32'(bus.downstream_txreq_id), 3);
    check("t4_b2b_vld", 32'(bus.downstream_txreq_vld), 1);
    check("t4_b2b_pld", 32'(bus.downstream_txreq_pld), 32'(pld_of(3)));
    check("t4_b2b_cnt", 32'(bus.ost_cnt), 4);
    bus.entry_txreq_vld = 8'h00;
    bus.downstream_rsp_vld = 1'b1; bus.downstream_rsp_id = 3'd3;

    // Load and response in the same cycle at ost_cnt==2
    step(); bus.downstream_rsp_id = 3'd5; #1;
    check("t5_done3", 32'(bus.linefill_done), 32'h08);
    check("t5_cnt3",  32'(bus.ost_cnt), 3);
    check("t5_idle",  32'(bus.downstream_txreq_vld), 0);
    step(); bus.downstream_rsp_id = 3'd7; bus.entry_txreq_vld = 8'h10; #1;
    check("t5_done5", 32'(bus.linefill_done), 32'h20);
    check("t5_cnt2",  32'(bus.ost_cnt), 2);
    check("t5_rdy4",  32'(bus.entry_txreq_rdy), 32'h10);
    step(); bus.downstream_rsp_vld = 1'b0; bus.entry_txreq_vld = 8'h00; #1;
    check("t5_cnt_same", 32'(bus.ost_cnt), 2);
    check("t5_id4",      32'(bus.downstream_txreq_id), 4);
    check("t5_vld4",     32'(bus.downstream_txreq_vld), 1);
    check("t5_done7",    32'(bus.linefill_done), 32'h80);
    step(); #1;
    check("t5_done_off", 32'(bus.linefill_done), 0);
    check("t5_ds_off",   32'(bus.downstream_txreq_vld), 0);

    // Drain to zero, then a spurious response sets the sticky error
    bus.downstream_rsp_vld = 1'b1; bus.downstream_rsp_id = 3'd0;
    step(); bus.downstream_rsp_id = 3'd1;
    step(); #1;
    check("t6_cnt0", 32'(bus.ost_cnt), 0);
    check("t6_err0", 32'(bus.ost_err), 0);
    bus.downstream_rsp_id = 3'd4;
    step(); bus.downstream_rsp_vld = 1'b0; #1;
    check("t6_cnt_hold", 32'(bus.ost_cnt), 0);
    check("t6_err_set",  32'(bus.ost_err), 1);
    step(); #1;
    check("t6_err_held", 32'(bus.ost_err), 1);
    bus.downstream_txreq_rdy = 1'b0; bus.entry_txreq_vld = 8'h01; #1;
    check("t6_rdy0", 32'(bus.entry_txreq_rdy), 32'h01);
    step(); bus.entry_txreq_vld = 8'h00; #1;
    check("t6_vld",  32'(bus.downstream_txreq_vld), 1);
    check("t6_cnt1", 32'(bus.ost_cnt), 1);
    step(); #1;
    check("t6_stall", 32'(bus.downstream_txreq_vld), 1);
    #1 rst_n = 1'b0; #1;
    check("t6_arst_vld",  32'(bus.downstream_txreq_vld), 0);
    check("t6_arst_pld",  32'(bus.downstream_txreq_pld), 0);
    check("t6_arst_cnt",  32'(bus.ost_cnt), 0);
    check("t6_arst_err",  32'(bus.ost_err), 0);
    check("t6_arst_done", 32'(bus.linefill_done), 0);
    @(negedge clk);
    rst_n = 1'b1; bus.downstream_txreq_rdy = 1'b1;
    step(); #1;
    check("t6_no_replay", 32'(bus.downstream_txreq_vld), 0);
    check("t6_cnt_post",  32'(bus.ost_cnt), 0);
    bus.entry_txreq_vld = 8'h81; #1;
    check("t6_prio0", 32'(bus.entry_txreq_rdy), 32'h01);
    step(); bus.entry_txreq_vld = 8'h00; #1;
    check("t6_post_id",  32'(bus.downstream_txreq_id), 0);
    check("t6_post_cnt", 32'(bus.ost_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
